// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed 7-segment scan controller.
// A prescaler paces digit slots; digit data is double-buffered (shadow/active)
// so the displayed frame only changes at a frame wrap.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module display_scan_ctrl #(
    parameter int unsigned CLK_DIV    = 100000,
    parameter int unsigned NUM_DIGITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  blank_in,
    input  logic        load,
    output logic [2:0]  sel,
    output logic        sel_en,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        pending,
    output logic        frame_done
);

    localparam int unsigned      CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
    localparam logic [2:0]       SEL_MAX = 3'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_sel;
    logic             r_sel_en;
    logic [6:0]       r_seg_n;
    logic             r_dp_n;
    logic             r_pending;
    logic             r_frame_done;
    logic [31:0]      r_act_data;
    logic [7:0]       r_act_dp;
    logic [7:0]       r_act_blank;
    logic [31:0]      r_sh_data;
    logic [7:0]       r_sh_dp;
    logic [7:0]       r_sh_blank;

    logic             w_tick;
    logic             w_wrap;
    logic [2:0]       w_sel_nxt;
    logic [31:0]      w_act_data_nxt;
    logic [7:0]       w_act_dp_nxt;
    logic [7:0]       w_act_blank_nxt;
    logic [3:0]       w_nib;
    logic             w_blank;
    logic             w_dp;
    logic             w_lz;

    // Hex nibble to active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign w_tick    = en && (r_cnt == CNT_MAX);
    assign w_wrap    = w_tick && (r_sel == SEL_MAX);
    assign w_sel_nxt = !w_tick ? r_sel : ((r_sel == SEL_MAX) ? 3'd0 : r_sel + 3'd1);

    // Active register next value: direct commit on load-at-wrap, else shadow commit at wrap
    always_comb begin
        w_act_data_nxt  = r_act_data;
        w_act_dp_nxt    = r_act_dp;
        w_act_blank_nxt = r_act_blank;
        if (w_wrap && load) begin
            w_act_data_nxt  = data_in;
            w_act_dp_nxt    = dp_in;
            w_act_blank_nxt = blank_in;
        end else if (w_wrap && r_pending) begin
            w_act_data_nxt  = r_sh_data;
            w_act_dp_nxt    = r_sh_dp;
            w_act_blank_nxt = r_sh_blank;
        end
    end

    // Select the digit that will be shown alongside the next sel value
    assign w_nib   = w_act_data_nxt[{w_sel_nxt, 2'b00} +: 4];
    assign w_blank = w_act_blank_nxt[w_sel_nxt];
    assign w_dp    = w_act_dp_nxt[w_sel_nxt];

`ifdef LEADING_ZERO_BLANK_EN
    // Blank a non-zero-index digit when it and every digit above it is zero
    always_comb begin
        w_lz = 1'b0;
        if (w_sel_nxt != 3'd0) begin
            w_lz = 1'b1;
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                if ((3'(k) >= w_sel_nxt) && (w_act_data_nxt[4*k +: 4] != 4'h0)) begin
                    w_lz = 1'b0;
                end
            end
        end
    end
`else
    assign w_lz = 1'b0;
`endif

    // Prescaler and digit index; both freeze while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_sel        <= 3'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
            r_sel        <= w_sel_nxt;
            if (en) begin
                r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
            end
        end
    end

    // Shadow capture, active commit and pending flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_data  <= '0;
            r_act_dp    <= '0;
            r_act_blank <= '0;
            r_sh_data   <= '0;
            r_sh_dp     <= '0;
            r_sh_blank  <= '0;
            r_pending   <= 1'b0;
        end else begin
            r_act_data  <= w_act_data_nxt;
            r_act_dp    <= w_act_dp_nxt;
            r_act_blank <= w_act_blank_nxt;
            if (load && !w_wrap) begin
                r_sh_data  <= data_in;
                r_sh_dp    <= dp_in;
                r_sh_blank <= blank_in;
                r_pending  <= 1'b1;
            end else if (w_wrap) begin
                r_pending  <= 1'b0;
            end
        end
    end

    // Registered drive outputs, aligned with sel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_en <= 1'b0;
            r_seg_n  <= 7'h7F;
            r_dp_n   <= 1'b1;
        end else begin
            r_sel_en <= en;
            if (en && !w_blank && !w_lz) begin
                r_seg_n <= hex_seg(w_nib);
                r_dp_n  <= ~w_dp;
            end else begin
                r_seg_n <= 7'h7F;
                r_dp_n  <= 1'b1;
            end
        end
    end

    assign sel        = r_sel;
    assign sel_en     = r_sel_en;
    assign seg_n      = r_seg_n;
    assign dp_n       = r_dp_n;
    assign pending    = r_pending;
    assign frame_done = r_frame_done;

endmodule
